// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues word fetches on a req/gnt/rvld bus,
// buffers returned words in order and presents the head to decode.
module ifu_fetch #(
    parameter int                XLEN            = 32,
    parameter logic [XLEN-1:0]   RESET_PC        = 32'h8000_0000,
    parameter int                FIFO_DEPTH      = 2,
    parameter int                MAX_OUTSTANDING = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    output logic            o_ibus_req,
    output logic [XLEN-1:0] o_ibus_addr,
    input  logic            i_ibus_gnt,
    input  logic            i_ibus_rvld,
    input  logic [XLEN-1:0] i_ibus_rdata,
    input  logic            i_stop,
    input  logic            i_flush,
    input  logic [XLEN-1:0] i_flush_addr,
    input  logic            i_bpu_taken,
    input  logic [XLEN-1:0] i_bpu_jaddr,
    output logic            o_data_vld,
    output logic [XLEN-1:0] o_iaddr,
    output logic [XLEN-1:0] o_data
);

    localparam int FAW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam int OAW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int OCW = $clog2(MAX_OUTSTANDING + 1);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [OCW-1:0]  live_q, live_d;
    logic [OCW-1:0]  kill_q, kill_d;

    logic [XLEN-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_data_q [FIFO_DEPTH];
    logic [FAW-1:0]  fifo_wr_q, fifo_wr_d;
    logic [FAW-1:0]  fifo_rd_q, fifo_rd_d;
    logic [FCW-1:0]  fifo_cnt_q, fifo_cnt_d;

    logic [XLEN-1:0] ifq_q [MAX_OUTSTANDING];
    logic [OAW-1:0]  ifq_wr_q, ifq_wr_d;
    logic [OAW-1:0]  ifq_rd_q, ifq_rd_d;

    logic            redirect;
    logic [XLEN-1:0] target;
    logic            fifo_empty;
    logic            fifo_credit;
    logic            bus_credit;
    logic            grant;
    logic            rsp_kill;
    logic            rsp_live;
    logic            push;
    logic            pop;

    function automatic logic [OAW-1:0] ifq_inc(input logic [OAW-1:0] p);
        return (p == OAW'(MAX_OUTSTANDING - 1)) ? '0 : p + OAW'(1);
    endfunction

    // A stalled predictor redirect is dropped; the predictor re-asserts it later.
    assign redirect    = i_flush | (i_bpu_taken & ~i_stop);
    assign target      = (i_flush ? i_flush_addr : i_bpu_jaddr) & ~XLEN'(3);
    assign fifo_empty  = (fifo_cnt_q == '0);
    assign fifo_credit = (32'(fifo_cnt_q) + 32'(live_q)) < 32'(FIFO_DEPTH);
    assign bus_credit  = (32'(live_q) + 32'(kill_q)) < 32'(MAX_OUTSTANDING);

    assign o_ibus_req  = ~i_rst & ~redirect & fifo_credit & bus_credit;
    assign o_ibus_addr = pc_q & ~XLEN'(3);
    assign grant       = o_ibus_req & i_ibus_gnt;

    // Responses retire stale (killed) requests first since the bus is in order.
    assign rsp_kill = i_ibus_rvld & (kill_q != '0);
    assign rsp_live = i_ibus_rvld & (kill_q == '0);
    assign push     = rsp_live & ~redirect;
    assign pop      = ~fifo_empty & ~i_stop;

    assign o_data_vld = ~i_rst & ~fifo_empty;
    assign o_iaddr    = o_data_vld ? fifo_addr_q[fifo_rd_q] : '0;
    assign o_data     = o_data_vld ? fifo_data_q[fifo_rd_q] : '0;

    always_comb begin
        pc_d       = pc_q;
        live_d     = live_q;
        kill_d     = kill_q;
        fifo_wr_d  = fifo_wr_q;
        fifo_rd_d  = fifo_rd_q;
        fifo_cnt_d = fifo_cnt_q;
        ifq_wr_d   = ifq_wr_q;
        ifq_rd_d   = ifq_rd_q;
        if (redirect) begin
            // Everything in flight becomes stale; a response this cycle retires one of them.
            pc_d       = target;
            live_d     = '0;
            kill_d     = kill_q + live_q + OCW'(grant) - OCW'(i_ibus_rvld);
            fifo_wr_d  = '0;
            fifo_rd_d  = '0;
            fifo_cnt_d = '0;
            ifq_wr_d   = '0;
            ifq_rd_d   = '0;
        end else begin
            if (grant) begin
                pc_d     = pc_q + XLEN'(4);
                ifq_wr_d = ifq_inc(ifq_wr_q);
            end
            if (rsp_live) begin
                ifq_rd_d = ifq_inc(ifq_rd_q);
            end
            live_d     = live_q + OCW'(grant) - OCW'(rsp_live);
            kill_d     = kill_q - OCW'(rsp_kill);
            fifo_wr_d  = fifo_wr_q + FAW'(push);
            fifo_rd_d  = fifo_rd_q + FAW'(pop);
            fifo_cnt_d = fifo_cnt_q + FCW'(push) - FCW'(pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc_q       <= RESET_PC;
            live_q     <= '0;
            kill_q     <= '0;
            fifo_wr_q  <= '0;
            fifo_rd_q  <= '0;
            fifo_cnt_q <= '0;
            ifq_wr_q   <= '0;
            ifq_rd_q   <= '0;
        end else begin
            pc_q       <= pc_d;
            live_q     <= live_d;
            kill_q     <= kill_d;
            fifo_wr_q  <= fifo_wr_d;
            fifo_rd_q  <= fifo_rd_d;
            fifo_cnt_q <= fifo_cnt_d;
            ifq_wr_q   <= ifq_wr_d;
            ifq_rd_q   <= ifq_rd_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (grant) begin
            ifq_q[ifq_wr_q] <= o_ibus_addr;
        end
        if (push) begin
            fifo_addr_q[fifo_wr_q] <= ifq_q[ifq_rd_q];
            fifo_data_q[fifo_wr_q] <= i_ibus_rdata;
        end
    end

    rsp_has_owner: assert property (@(posedge i_clk) disable iff (i_rst)
        i_ibus_rvld |-> ((live_q != '0) || (kill_q != '0)));

endmodule
